// File: rtl/normal_mode.sv
// Two-lane traffic light phase controller for normal operation.
// Runs G1R2 -> Y1R2 -> R1G2 -> R1Y2 on 1 Hz ticks using shadowed
// green/yellow/red durations. It returns to IDLE when enable drops.
//
//   state | meaning
//   ------+---------------------------------------------
//   IDLE  | config mode owns display; both red, times 0
//   G1R2  | lane 1 green, lane 2 red
//   Y1R2  | lane 1 yellow, lane 2 red
//   R1G2  | lane 1 red, lane 2 green
//   R1Y2  | lane 1 red, lane 2 yellow
module normal_mode #(
  parameter int TIME_W   = 7,
  parameter int MAX_TIME = 99,
  parameter int MIN_TIME = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              tick,
  input  logic [TIME_W-1:0] greenTime,
  input  logic [TIME_W-1:0] yellowTime,
  input  logic [TIME_W-1:0] redTime,
  output logic [2:0]        lightLane1,
  output logic [2:0]        lightLane2,
  output logic [TIME_W-1:0] timeLane1,
  output logic [TIME_W-1:0] timeLane2,
  output logic [2:0]        state,
  output logic              cycleDone
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_G1R2 = 3'd1,
    ST_Y1R2 = 3'd2,
    ST_R1G2 = 3'd3,
    ST_R1Y2 = 3'd4
  } state_t;

  localparam logic [TIME_W-1:0] MAX_T = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] MIN_T = TIME_W'(MIN_TIME);
  localparam logic [TIME_W-1:0] ONE_T = TIME_W'(1);
  localparam logic [2:0]        LAMP_R = 3'b100;
  localparam logic [2:0]        LAMP_Y = 3'b010;
  localparam logic [2:0]        LAMP_G = 3'b001;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] time1_q, time1_d;
  logic [TIME_W-1:0] time2_q, time2_d;
  logic [TIME_W-1:0] gs_q, gs_d;
  logic [TIME_W-1:0] ys_q, ys_d;
  logic [TIME_W-1:0] rs_q, rs_d;
  logic              cycle_done_q, cycle_done_d;
  logic [2:0]        light1_q, light1_d;
  logic [2:0]        light2_q, light2_d;

  logic [TIME_W-1:0] green_c, yellow_c, red_c;

  // Out-of-range durations are clamped into [MIN_TIME, MAX_TIME].
  function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] v);
    logic [TIME_W-1:0] r;
    if (v == '0) begin
      r = MIN_T;
    end else if (v > MAX_T) begin
      r = MAX_T;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Red-lane countdown: stops at 1 so the waiting lane never shows 0.
  function automatic logic [TIME_W-1:0] sat_dec(input logic [TIME_W-1:0] v);
    logic [TIME_W-1:0] r;
    if (v > ONE_T) begin
      r = v - ONE_T;
    end else begin
      r = ONE_T;
    end
    return r;
  endfunction

  function automatic logic [2:0] lamp_lane1(input state_t s);
    logic [2:0] r;
    case (s)
      ST_G1R2: r = LAMP_G;
      ST_Y1R2: r = LAMP_Y;
      default: r = LAMP_R;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] lamp_lane2(input state_t s);
    logic [2:0] r;
    case (s)
      ST_R1G2: r = LAMP_G;
      ST_R1Y2: r = LAMP_Y;
      default: r = LAMP_R;
    endcase
    return r;
  endfunction

  // Conditioned copies of the live inputs, consumed only at cycle start.
  always_comb begin
    green_c  = clamp_time(greenTime);
    yellow_c = clamp_time(yellowTime);
    red_c    = clamp_time(redTime);
  end

  // Next-state, counter and shadow logic.
  always_comb begin
    state_d      = state_q;
    time1_d      = time1_q;
    time2_d      = time2_q;
    gs_d         = gs_q;
    ys_d         = ys_q;
    rs_d         = rs_q;
    cycle_done_d = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      time1_d = '0;
      time2_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_G1R2;
          gs_d    = green_c;
          ys_d    = yellow_c;
          rs_d    = red_c;
          time1_d = green_c;
          time2_d = red_c;
        end
        ST_G1R2: begin
          if (tick) begin
            time2_d = sat_dec(time2_q);
            if (time1_q > ONE_T) begin
              time1_d = time1_q - ONE_T;
            end else begin
              state_d = ST_Y1R2;
              time1_d = ys_q;
            end
          end
        end
        ST_Y1R2: begin
          if (tick) begin
            time2_d = sat_dec(time2_q);
            if (time1_q > ONE_T) begin
              time1_d = time1_q - ONE_T;
            end else begin
              state_d = ST_R1G2;
              time1_d = rs_q;
              time2_d = gs_q;
            end
          end
        end
        ST_R1G2: begin
          if (tick) begin
            time1_d = sat_dec(time1_q);
            if (time2_q > ONE_T) begin
              time2_d = time2_q - ONE_T;
            end else begin
              state_d = ST_R1Y2;
              time2_d = ys_q;
            end
          end
        end
        ST_R1Y2: begin
          if (tick) begin
            time1_d = sat_dec(time1_q);
            if (time2_q > ONE_T) begin
              time2_d = time2_q - ONE_T;
            end else begin
              // New cycle: pick up any durations confirmed since last start.
              state_d      = ST_G1R2;
              gs_d         = green_c;
              ys_d         = yellow_c;
              rs_d         = red_c;
              time1_d      = green_c;
              time2_d      = red_c;
              cycle_done_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          time1_d = '0;
          time2_d = '0;
        end
      endcase
    end

    // Lamps are decoded from the next state so they register alongside it.
    light1_d = lamp_lane1(state_d);
    light2_d = lamp_lane2(state_d);
  end

  // State, counters, shadows and lamp registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      time1_q      <= '0;
      time2_q      <= '0;
      gs_q         <= MIN_T;
      ys_q         <= MIN_T;
      rs_q         <= MIN_T;
      cycle_done_q <= 1'b0;
      light1_q     <= LAMP_R;
      light2_q     <= LAMP_R;
    end else begin
      state_q      <= state_d;
      time1_q      <= time1_d;
      time2_q      <= time2_d;
      gs_q         <= gs_d;
      ys_q         <= ys_d;
      rs_q         <= rs_d;
      cycle_done_q <= cycle_done_d;
      light1_q     <= light1_d;
      light2_q     <= light2_d;
    end
  end

  // Output mapping.
  always_comb begin
    lightLane1 = light1_q;
    lightLane2 = light2_q;
    timeLane1  = time1_q;
    timeLane2  = time2_q;
    state      = state_q;
    cycleDone  = cycle_done_q;
  end

endmodule

// File: tb/tb_normal_mode.sv
// Self-checking bench for normal_mode: directed scenarios with literal
// expectations plus a per-cycle comparison against a phase-level model.
module tb_normal_mode;

  logic       clk = 1'b0;
  logic       reset, enable, tick;
  logic [6:0] g, y, r;
  logic [2:0] lightLane1, lightLane2, state;
  logic [6:0] timeLane1, timeLane2;
  logic       cycleDone;

  int tests = 0;
  int fails = 0;

  normal_mode dut (
    .clk(clk), .reset(reset), .enable(enable), .tick(tick),
    .greenTime(g), .yellowTime(y), .redTime(r),
    .lightLane1(lightLane1), .lightLane2(lightLane2),
    .timeLane1(timeLane1), .timeLane2(timeLane2),
    .state(state), .cycleDone(cycleDone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- phase-level model ----------------
  // phase 0 idle, 1..4 = G1R2,Y1R2,R1G2,R1Y2. tl[0]/tl[1] lane times.
  // sh[0..2] = green/yellow/red shadows.
  int m_phase;
  int tl[2];
  int sh[3];
  int m_cd;
  int m_act, m_red;
  int lamp1_tab[5] = '{4, 1, 2, 4, 4};
  int lamp2_tab[5] = '{4, 4, 4, 1, 2};

  function automatic int condt(input int v);
    if (v == 0) return 1;
    if (v > 99) return 99;
    return v;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; tl[0] = 0; tl[1] = 0; m_cd = 0;
      sh[0] = 1; sh[1] = 1; sh[2] = 1;
    end else begin
      m_cd = 0;
      if (!enable) begin
        m_phase = 0; tl[0] = 0; tl[1] = 0;
      end else if (m_phase == 0) begin
        sh[0] = condt(g); sh[1] = condt(y); sh[2] = condt(r);
        m_phase = 1; tl[0] = sh[0]; tl[1] = sh[2];
      end else if (tick) begin
        m_act = (m_phase <= 2) ? 0 : 1;
        m_red = 1 - m_act;
        tl[m_red] = (tl[m_red] > 1) ? tl[m_red] - 1 : 1;
        if (tl[m_act] > 1) begin
          tl[m_act] = tl[m_act] - 1;
        end else begin
          m_phase = (m_phase == 4) ? 1 : m_phase + 1;
          case (m_phase)
            2: tl[0] = sh[1];
            3: begin tl[0] = sh[2]; tl[1] = sh[0]; end
            4: tl[1] = sh[1];
            default: begin
              sh[0] = condt(g); sh[1] = condt(y); sh[2] = condt(r);
              tl[0] = sh[0]; tl[1] = sh[2]; m_cd = 1;
            end
          endcase
        end
      end
    end
  end

  // Per-cycle compare against the model plus lamp safety checks.
  always @(negedge clk) begin
    chk("state", int'(state), m_phase);
    chk("lamp1", int'(lightLane1), lamp1_tab[m_phase]);
    chk("lamp2", int'(lightLane2), lamp2_tab[m_phase]);
    chk("time1", int'(timeLane1), tl[0]);
    chk("time2", int'(timeLane2), tl[1]);
    chk("cycleDone", int'(cycleDone), m_cd);
    chk("onehot1", int'($onehot(lightLane1)), 1);
    chk("onehot2", int'($onehot(lightLane2)), 1);
    chk("both_nonred", int'(!lightLane1[2] && !lightLane2[2]), 0);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit t);
    tick = t;
    @(posedge clk);
    #2;
  endtask

  task automatic do_tick(input int gap);
    repeat (gap - 1) cyc(1'b0);
    cyc(1'b1);
  endtask

  int exp1[16]  = '{4, 3, 2, 1, 3, 2, 1, 8, 7, 6, 5, 4, 3, 2, 1, 5};
  int exp2[16]  = '{7, 6, 5, 4, 3, 2, 1, 5, 4, 3, 2, 1, 3, 2, 1, 8};
  int expst[16] = '{1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 4, 4, 4, 1};
  int nticks;
  int ncyc;
  int min_t2;

  initial begin
    reset = 1'b1; enable = 1'b0; tick = 1'b0;
    g = 7'd5; y = 7'd3; r = 7'd8;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    cyc(1'b0);
    chk("rst_state", int'(state), 0);
    chk("rst_lamps", int'({lightLane1, lightLane2}), 6'b100100);
    chk("rst_times", int'({timeLane1, timeLane2}), 0);

    // Reset mid-G1R2 takes effect before the next edge.
    enable = 1'b1;
    cyc(1'b0);
    chk("entry_state", int'(state), 1);
    do_tick(10);
    chk("g1r2_t1", int'(timeLane1), 4);
    reset = 1'b1;
    #1;
    chk("async_state", int'(state), 0);
    chk("async_lamps", int'({lightLane1, lightLane2}), 6'b100100);
    chk("async_times", int'({timeLane1, timeLane2}), 0);
    cyc(1'b0);
    reset = 1'b0;
    cyc(1'b0);
    chk("restart_state", int'(state), 1);
    chk("restart_t1", int'(timeLane1), 5);
    chk("restart_t2", int'(timeLane2), 8);

    // Full 16-tick cycle with g=5 y=3 r=8.
    for (int i = 0; i < 16; i++) begin
      do_tick(10);
      chk("seq_t1", int'(timeLane1), exp1[i]);
      chk("seq_t2", int'(timeLane2), exp2[i]);
      chk("seq_state", int'(state), expst[i]);
      if (i == 15) chk("seq_cycleDone", int'(cycleDone), 1);
    end
    cyc(1'b0);
    chk("cd_pulse_end", int'(cycleDone), 0);

    // Green change mid-cycle only takes effect at the next cycle start.
    repeat (5) do_tick(2);
    chk("chg_in_y", int'(state), 2);
    g = 7'd10;
    repeat (2) do_tick(2);
    chk("chg_y_t1", int'(timeLane1), 1);
    do_tick(2);
    chk("chg_r1g2_t2", int'(timeLane2), 5);
    repeat (5) do_tick(2);
    chk("chg_r1y2", int'(state), 4);
    repeat (3) do_tick(2);
    chk("chg_new_state", int'(state), 1);
    chk("chg_new_t1", int'(timeLane1), 10);
    chk("chg_new_t2", int'(timeLane2), 8);

    // Clamping: g=0 -> 1, y=120 -> 99, r=50.
    enable = 1'b0;
    cyc(1'b0);
    chk("idle_state", int'(state), 0);
    g = 7'd0; y = 7'd120; r = 7'd50;
    enable = 1'b1;
    cyc(1'b0);
    chk("clamp_t1", int'(timeLane1), 1);
    chk("clamp_t2", int'(timeLane2), 50);
    do_tick(1);
    chk("clamp_y_state", int'(state), 2);
    chk("clamp_y_t1", int'(timeLane1), 99);
    chk("clamp_y_t2", int'(timeLane2), 49);
    min_t2 = 99;
    repeat (98) begin
      do_tick(1);
      if (int'(timeLane2) < min_t2) min_t2 = int'(timeLane2);
    end
    chk("sat_t1", int'(timeLane1), 1);
    chk("sat_min_t2", min_t2, 1);
    do_tick(1);
    chk("clamp_r1g2_state", int'(state), 3);
    chk("clamp_r1g2_t1", int'(timeLane1), 50);
    chk("clamp_r1g2_t2", int'(timeLane2), 1);

    // Enable drop with coincident tick during R1G2.
    enable = 1'b0;
    cyc(1'b1);
    chk("drop_state", int'(state), 0);
    chk("drop_lamps", int'({lightLane1, lightLane2}), 6'b100100);
    chk("drop_times", int'({timeLane1, timeLane2}), 0);
    chk("drop_cd", int'(cycleDone), 0);
    enable = 1'b1;
    cyc(1'b0);
    chk("reraise_state", int'(state), 1);

    // Random soak: enable toggles rarely, ticks ~1 in 3, inputs wander.
    g = 7'd4; y = 7'd2; r = 7'd6;
    nticks = 0;
    ncyc = 0;
    while (nticks < 2000 && ncyc < 20000) begin
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 99) == 0) begin
        g = 7'($urandom_range(0, 127));
        y = 7'($urandom_range(0, 12));
        r = 7'($urandom_range(0, 20));
      end
      if ($urandom_range(0, 2) == 0) begin
        nticks++;
        cyc(1'b1);
      end else begin
        cyc(1'b0);
      end
      ncyc++;
    end
    chk("soak_ticks", nticks, 2000);

    tick = 1'b0;
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
